// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback/retire stage: load wait, extract/extend, regfile write, ordered retire
// One entry in flight at most; a load parks the stage in WAIT_LOAD until its data pulse arrives.

module wb_stage #(
   parameter int ORDER_W = 64,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_pc,
   input  logic [31:0]        in_inst,
   input  logic [4:0]         in_rd_s,
   input  logic               in_regf_we,
   input  logic               in_mem_read,
   input  logic [2:0]         in_funct3,
   input  logic [31:0]        in_result,
   input  logic               dmem_resp,
   input  logic [31:0]        dmem_rdata,
   output logic               valid_write,
   output logic               regf_we,
   output logic [4:0]         rd_s,
   output logic [31:0]        rd_v,
   output logic [ORDER_W-1:0] retire_order,
   output logic [31:0]        retire_pc,
   output logic [31:0]        retire_inst,
   output logic               misalign_err,
   output logic               load_timeout_err
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   logic [0:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        inst_q, inst_d;
   logic [4:0]         rd_q, rd_d;
   logic               we_q, we_d;
   logic [2:0]         f3_q, f3_d;
   logic [1:0]         addr_q, addr_d;
   logic [ORDER_W-1:0] order_q, order_d;

   logic               valid_write_q, valid_write_d;
   logic               regf_we_q, regf_we_d;
   logic [4:0]         rd_s_q, rd_s_d;
   logic [31:0]        rd_v_q, rd_v_d;
   logic [ORDER_W-1:0] retire_order_q, retire_order_d;
   logic [31:0]        retire_pc_q, retire_pc_d;
   logic [31:0]        retire_inst_q, retire_inst_d;
   logic               misalign_q, misalign_d;
   logic               tmo_err_q, tmo_err_d;

   logic [7:0]         ld_byte;
   logic [15:0]        ld_half;
   logic [31:0]        ld_data;

   logic               ret_fire;
   logic [31:0]        ret_pc, ret_inst, ret_val;
   logic [4:0]         ret_rd;
   logic               ret_we;

   // Misaligned halves/words fall back to the aligned-down lane through addr_q indexing.
   always_comb begin
      ld_byte = 8'h00;
      ld_data = 32'h0;
      case (addr_q)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b010:  ld_data = dmem_rdata;
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = 32'h0;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      pc_d           = pc_q;
      inst_d         = inst_q;
      rd_d           = rd_q;
      we_d           = we_q;
      f3_d           = f3_q;
      addr_d         = addr_q;
      order_d        = order_q;
      misalign_d     = misalign_q;
      tmo_err_d      = tmo_err_q;
      ret_fire       = 1'b0;
      ret_pc         = in_pc;
      ret_inst       = in_inst;
      ret_rd         = in_rd_s;
      ret_we         = in_regf_we;
      ret_val        = in_result;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_mem_read) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
                  pc_d    = in_pc;
                  inst_d  = in_inst;
                  rd_d    = in_rd_s;
                  we_d    = in_regf_we;
                  f3_d    = in_funct3;
                  addr_d  = in_result[1:0];
                  if (((in_funct3 == 3'b001 || in_funct3 == 3'b101) && in_result[0]) ||
                      (in_funct3 == 3'b010 && in_result[1:0] != 2'b00))
                     misalign_d = 1'b1;
               end else begin
                  ret_fire = 1'b1;
               end
            end
         end
         default: begin
            if (cnt_q == TMO)
               tmo_err_d = 1'b1;
            else
               cnt_d = cnt_q + 1'b1;
            if (dmem_resp) begin
               state_d  = S_IDLE;
               ret_fire = 1'b1;
               ret_pc   = pc_q;
               ret_inst = inst_q;
               ret_rd   = rd_q;
               ret_we   = we_q;
               ret_val  = ld_data;
            end
         end
      endcase

      // Write-port index/data hold their last value between retires.
      valid_write_d  = ret_fire;
      regf_we_d      = ret_fire & ret_we & (ret_rd != 5'd0);
      rd_s_d         = rd_s_q;
      rd_v_d         = rd_v_q;
      retire_order_d = retire_order_q;
      retire_pc_d    = retire_pc_q;
      retire_inst_d  = retire_inst_q;
      if (ret_fire) begin
         rd_s_d         = ret_rd;
         rd_v_d         = ret_val;
         retire_order_d = order_q;
         retire_pc_d    = ret_pc;
         retire_inst_d  = ret_inst;
         order_d        = order_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         pc_q           <= '0;
         inst_q         <= '0;
         rd_q           <= '0;
         we_q           <= 1'b0;
         f3_q           <= '0;
         addr_q         <= '0;
         order_q        <= '0;
         valid_write_q  <= 1'b0;
         regf_we_q      <= 1'b0;
         rd_s_q         <= '0;
         rd_v_q         <= '0;
         retire_order_q <= '0;
         retire_pc_q    <= '0;
         retire_inst_q  <= '0;
         misalign_q     <= 1'b0;
         tmo_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         pc_q           <= pc_d;
         inst_q         <= inst_d;
         rd_q           <= rd_d;
         we_q           <= we_d;
         f3_q           <= f3_d;
         addr_q         <= addr_d;
         order_q        <= order_d;
         valid_write_q  <= valid_write_d;
         regf_we_q      <= regf_we_d;
         rd_s_q         <= rd_s_d;
         rd_v_q         <= rd_v_d;
         retire_order_q <= retire_order_d;
         retire_pc_q    <= retire_pc_d;
         retire_inst_q  <= retire_inst_d;
         misalign_q     <= misalign_d;
         tmo_err_q      <= tmo_err_d;
      end
   end

   assign in_ready         = (state_q == S_IDLE);
   assign valid_write      = valid_write_q;
   assign regf_we          = regf_we_q;
   assign rd_s             = rd_s_q;
   assign rd_v             = rd_v_q;
   assign retire_order     = retire_order_q;
   assign retire_pc        = retire_pc_q;
   assign retire_inst      = retire_inst_q;
   assign misalign_err     = misalign_q;
   assign load_timeout_err = tmo_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage
// Stimulus pushes expected retires; a negedge monitor pops and compares on valid_write.

module tb_wb_stage;

   localparam int ORDER_W = 64;
   localparam int TMO     = 12;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_pc, in_inst, in_result, dmem_rdata;
   logic [4:0]         in_rd_s;
   logic               in_regf_we, in_mem_read, dmem_resp;
   logic [2:0]         in_funct3;
   logic               valid_write, regf_we, misalign_err, load_timeout_err;
   logic [4:0]         rd_s;
   logic [31:0]        rd_v, retire_pc, retire_inst;
   logic [ORDER_W-1:0] retire_order;

   typedef struct {
      logic [4:0]  rd;
      logic        we;
      logic [31:0] v;
      logic [63:0] ord;
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] exp_order;
   int          total = 0;
   int          bad   = 0;

   wb_stage #(.ORDER_W(ORDER_W), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .in_rd_s(in_rd_s), .in_regf_we(in_regf_we),
      .in_mem_read(in_mem_read), .in_funct3(in_funct3), .in_result(in_result),
      .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
      .valid_write(valid_write), .regf_we(regf_we), .rd_s(rd_s), .rd_v(rd_v),
      .retire_order(retire_order), .retire_pc(retire_pc), .retire_inst(retire_inst),
      .misalign_err(misalign_err), .load_timeout_err(load_timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [4:0] rd, input logic we, input logic [31:0] v,
                           input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.rd   = rd;
      e.we   = we && (rd != 5'd0);
      e.v    = v;
      e.ord  = exp_order;
      e.pc   = pc;
      e.inst = inst;
      exp_q.push_back(e);
      exp_order++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one entry for one cycle; caller drops in_valid when the burst ends.
   task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                       input logic we, input logic mr, input logic [2:0] f3,
                       input logic [31:0] res);
      in_valid    = 1'b1;
      in_pc       = pc;
      in_inst     = inst;
      in_rd_s     = rd;
      in_regf_we  = we;
      in_mem_read = mr;
      in_funct3   = f3;
      in_result   = res;
      @(negedge clk);
      check("in_ready_at_accept", 64'(in_ready), 64'd1);
      tick();
   endtask

   task automatic alu(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                      input logic [31:0] res);
      push_exp(rd, we, res, pc, pc ^ 32'h13);
      send(pc, pc ^ 32'h13, rd, we, 1'b0, 3'b000, res);
   endtask

   // Load with response sampled dly cycles after the accept edge.
   task automatic load(input logic [31:0] pc, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rdata, input int dly,
                       input logic [31:0] expv);
      push_exp(rd, 1'b1, expv, pc, 32'h03 | {17'h0, f3, 12'h0});
      send(pc, 32'h03 | {17'h0, f3, 12'h0}, rd, 1'b1, 1'b1, f3, addr);
      in_valid = 1'b0;
      for (int i = 0; i < dly - 1; i++) begin
         @(negedge clk);
         check("in_ready_wait", 64'(in_ready), 64'd0);
         tick();
      end
      dmem_resp  = 1'b1;
      dmem_rdata = rdata;
      @(negedge clk);
      check("in_ready_resp_cycle", 64'(in_ready), 64'd0);
      tick();
      dmem_resp = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && valid_write) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_retire: got rd_v=%h order=%0d expected none", rd_v, retire_order);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rd_s", 64'(rd_s), 64'(e.rd));
            check("regf_we", 64'(regf_we), 64'(e.we));
            check("rd_v", 64'(rd_v), 64'(e.v));
            check("retire_order", retire_order, e.ord);
            check("retire_pc", 64'(retire_pc), 64'(e.pc));
            check("retire_inst", 64'(retire_inst), 64'(e.inst));
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_rd_s = '0;
      in_regf_we = 1'b0; in_mem_read = 1'b0; in_funct3 = '0; in_result = '0;
      dmem_resp = 1'b0; dmem_rdata = '0; exp_order = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid_write", 64'(valid_write), 64'd0);
      check("rst_rd_v", 64'(rd_v), 64'd0);
      check("rst_order", retire_order, 64'd0);
      check("rst_misalign", 64'(misalign_err), 64'd0);
      check("rst_timeout", 64'(load_timeout_err), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      alu(32'h100, 5'd5, 1'b1, 32'h0000_0011);
      alu(32'h104, 5'd1, 1'b1, 32'hAAAA_0001);
      alu(32'h108, 5'd2, 1'b1, 32'hBBBB_0002);
      alu(32'h10C, 5'd3, 1'b1, 32'hCCCC_0003);
      in_valid = 1'b0;
      tick();

      load(32'h200, 5'd10, 3'b000, 32'h1003, 32'h80FF_FF7F, 4, 32'hFFFF_FF80);
      load(32'h204, 5'd11, 3'b100, 32'h1003, 32'h80FF_FF7F, 4, 32'h0000_0080);
      load(32'h208, 5'd12, 3'b101, 32'h1002, 32'h80FF_FF7F, 2, 32'h0000_80FF);
      load(32'h20C, 5'd13, 3'b001, 32'h1002, 32'h80FF_FF7F, 1, 32'hFFFF_80FF);
      load(32'h210, 5'd14, 3'b010, 32'h1000, 32'h80FF_FF7F, 3, 32'h80FF_FF7F);
      load(32'h214, 5'd15, 3'b000, 32'h1000, 32'h80FF_FF7F, 1, 32'h0000_007F);
      load(32'h218, 5'd16, 3'b011, 32'h1000, 32'h80FF_FF7F, 1, 32'h0000_0000);

      alu(32'h300, 5'd7, 1'b0, 32'h0000_1234);
      alu(32'h304, 5'd0, 1'b1, 32'h0000_5555);
      in_valid = 1'b0;
      // A stray response while idle must not retire anything.
      dmem_resp = 1'b1;
      tick();
      dmem_resp = 1'b0;
      tick();
      check("no_misalign_yet", 64'(misalign_err), 64'd0);
      check("idle_regf_we_low", 64'(regf_we), 64'd0);

      push_exp(5'd9, 1'b1, 32'h1357_9BDF, 32'h400, 32'h0000_2003);
      send(32'h400, 32'h0000_2003, 5'd9, 1'b1, 1'b1, 3'b010, 32'h2002);
      in_valid = 1'b0;
      @(negedge clk);
      check("misalign_set", 64'(misalign_err), 64'd1);
      check("timeout_not_yet", 64'(load_timeout_err), 64'd0);
      repeat (TMO + 3) tick();
      @(negedge clk);
      check("timeout_set", 64'(load_timeout_err), 64'd1);
      check("in_ready_stalled", 64'(in_ready), 64'd0);
      tick();
      dmem_resp = 1'b1; dmem_rdata = 32'h1357_9BDF;
      tick();
      dmem_resp = 1'b0;
      tick();
      check("misalign_sticky", 64'(misalign_err), 64'd1);
      check("timeout_sticky", 64'(load_timeout_err), 64'd1);

      send(32'h500, 32'h0000_0003, 5'd4, 1'b1, 1'b1, 3'b000, 32'h3000);
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_order = '0;
      dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      tick();
      dmem_resp = 1'b0;
      tick();
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      check("post_rst_misalign", 64'(misalign_err), 64'd0);
      check("post_rst_timeout", 64'(load_timeout_err), 64'd0);
      tick();
      alu(32'h600, 5'd6, 1'b1, 32'h0000_0066);
      in_valid = 1'b0;

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
